// File: rtl/perf_tcp_client_gen.sv
// perf_tcp_client_gen
//   Traffic generator for the TCP client performance example. A runTx pulse
//   latches the run parameters, opens min(numSessions, MAX_SESSIONS) sessions
//   to serverIpAddress:SERVER_PORT, then sends TotalPkgPerConn packets of
//   pkgWordCount 64-byte beats per session, round-robin across the sessions
//   that opened successfully. Only one packet is outstanding at a time.
//
// Ports
//   aclk, aresetn           clock, synchronous active-low reset
//   runTx + run params      start pulse, numSessions, pkgWordCount,
//                           serverIpAddress, TotalPkgPerConn
//   open_req_* / open_rsp_* session open request / response
//   tx_meta_* / tx_stat_*   per-packet meta request / status response
//   tx_data_*               AXI-Stream payload (tdata/tkeep/tlast)
//   close_req_*             session close requests (macro build only)
//   busy, done              run in progress / one-cycle end-of-run pulse
//   open_fail_cnt,retry_cnt failed opens / tx retries of the last run
//
// Build option
//   PERF_TCP_CLIENT_CLOSE_EN  adds the CLOSE state and close_req_* ports;
//                             sessions are closed in table order at run end.
module perf_tcp_client_gen #(
    parameter int          MAX_SESSIONS = 64,
    parameter logic [15:0] SERVER_PORT  = 16'd5001,
    parameter int          DATA_BITS    = 512
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   runTx,
    input  logic [15:0]            numSessions,
    input  logic [7:0]             pkgWordCount,
    input  logic [31:0]            serverIpAddress,
    input  logic [7:0]             TotalPkgPerConn,
    output logic                   open_req_valid,
    input  logic                   open_req_ready,
    output logic [31:0]            open_req_ip,
    output logic [15:0]            open_req_port,
    input  logic                   open_rsp_valid,
    output logic                   open_rsp_ready,
    input  logic [15:0]            open_rsp_sid,
    input  logic                   open_rsp_success,
    output logic                   tx_meta_valid,
    input  logic                   tx_meta_ready,
    output logic [15:0]            tx_meta_sid,
    output logic [15:0]            tx_meta_len,
    input  logic                   tx_stat_valid,
    output logic                   tx_stat_ready,
    input  logic [15:0]            tx_stat_sid,
    input  logic [1:0]             tx_stat_error,
    output logic                   tx_data_tvalid,
    input  logic                   tx_data_tready,
    output logic [DATA_BITS-1:0]   tx_data_tdata,
    output logic [DATA_BITS/8-1:0] tx_data_tkeep,
    output logic                   tx_data_tlast,
`ifdef PERF_TCP_CLIENT_CLOSE_EN
    output logic                   close_req_valid,
    input  logic                   close_req_ready,
    output logic [15:0]            close_req_sid,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            open_fail_cnt,
    output logic [31:0]            retry_cnt
);

    localparam int          SW    = (MAX_SESSIONS > 1) ? $clog2(MAX_SESSIONS) : 1;
    localparam int          NW    = DATA_BITS / 64;
    localparam logic [15:0] MAX16 = 16'(MAX_SESSIONS);

    typedef enum logic [2:0] {
        S_IDLE, S_OPEN, S_META, S_WAIT, S_DATA, S_CLOSE, S_FINISH
    } state_t;

`ifdef PERF_TCP_CLIENT_CLOSE_EN
    localparam state_t S_END = S_CLOSE;
`else
    localparam state_t S_END = S_FINISH;
`endif

    state_t      r_state, w_state_nxt;

    logic [15:0] r_target;
    logic [7:0]  r_words;
    logic [31:0] r_ip;
    logic [7:0]  r_pkts;
    logic [15:0] r_req_cnt, r_rsp_cnt, r_ok_cnt, r_fail_cnt;
    logic [31:0] r_retry_cnt;
    logic [15:0] r_sp;
    logic [7:0]  r_beat;
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_done_sess;
    logic [15:0] r_sid_tab [MAX_SESSIONS];
    logic [7:0]  r_sent    [MAX_SESSIONS];

    logic        w_req_hs, w_rsp_hs, w_meta_hs, w_stat_hs, w_data_hs;
    logic        w_skip, w_last_beat, w_sess_full, w_all_done;
    logic [15:0] w_sp_inc, w_sp_next;
    logic [63:0] w_word;
    logic        w_unused_ok;

    assign w_req_hs  = open_req_valid & open_req_ready;
    assign w_rsp_hs  = open_rsp_valid & open_rsp_ready;
    assign w_meta_hs = tx_meta_valid  & tx_meta_ready;
    assign w_stat_hs = tx_stat_valid  & tx_stat_ready;
    assign w_data_hs = tx_data_tvalid & tx_data_tready;

    // A session that already sent its quota is stepped over one cycle at a
    // time in SEND_META; meta valid is never raised for it.
    assign w_skip      = (r_sent[r_sp[SW-1:0]] == r_pkts);
    assign w_last_beat = (r_beat == (r_words - 8'd1));
    assign w_sess_full = ((r_sent[r_sp[SW-1:0]] + 8'd1) == r_pkts);
    assign w_all_done  = w_sess_full && ((r_done_sess + 16'd1) == r_ok_cnt);
    assign w_sp_inc    = r_sp + 16'd1;
    assign w_sp_next   = (w_sp_inc == r_ok_cnt) ? 16'd0 : w_sp_inc;

    // Outputs decode from registered state/counters only.
    assign open_req_valid = (r_state == S_OPEN) && (r_req_cnt != r_target);
    assign open_req_ip    = r_ip;
    assign open_req_port  = SERVER_PORT;
    assign open_rsp_ready = (r_state == S_OPEN);
    assign tx_meta_valid  = (r_state == S_META) && !w_skip;
    assign tx_meta_sid    = r_sid_tab[r_sp[SW-1:0]];
    assign tx_meta_len    = {2'b00, r_words, 6'b000000};
    assign tx_stat_ready  = (r_state == S_WAIT);
    assign tx_data_tvalid = (r_state == S_DATA);
    assign tx_data_tkeep  = '1;
    assign tx_data_tlast  = w_last_beat;
    assign w_word         = {r_sp, r_pkt_cnt, 24'd0, r_beat};
    assign busy           = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign done           = (r_state == S_FINISH);
    assign open_fail_cnt  = r_fail_cnt;
    assign retry_cnt      = r_retry_cnt;
    assign w_unused_ok    = ^tx_stat_sid;

    for (genvar g = 0; g < NW; g++) begin : g_lane
        assign tx_data_tdata[g*64 +: 64] = w_word;
    end

`ifdef PERF_TCP_CLIENT_CLOSE_EN
    logic [15:0] r_close_idx;
    logic        w_close_hs;
    assign close_req_valid = (r_state == S_CLOSE) && (r_close_idx != r_ok_cnt);
    assign close_req_sid   = r_sid_tab[r_close_idx[SW-1:0]];
    assign w_close_hs      = close_req_valid & close_req_ready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_close_idx <= '0;
        end else if (r_state == S_IDLE && runTx) begin
            r_close_idx <= '0;
        end else if (w_close_hs) begin
            r_close_idx <= r_close_idx + 16'd1;
        end
    end
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (runTx) w_state_nxt = S_OPEN;
            S_OPEN:   if (r_rsp_cnt == r_target) begin
                          if (r_ok_cnt == 16'd0 || r_words == 8'd0 || r_pkts == 8'd0)
                              w_state_nxt = S_END;
                          else
                              w_state_nxt = S_META;
                      end
            S_META:   if (w_meta_hs) w_state_nxt = S_WAIT;
            S_WAIT:   if (w_stat_hs)
                          w_state_nxt = (tx_stat_error == 2'd0) ? S_DATA : S_META;
            S_DATA:   if (w_data_hs && w_last_beat)
                          w_state_nxt = w_all_done ? S_END : S_META;
`ifdef PERF_TCP_CLIENT_CLOSE_EN
            S_CLOSE:  if ((r_close_idx == r_ok_cnt) ||
                          (w_close_hs && (r_close_idx + 16'd1) == r_ok_cnt))
                          w_state_nxt = S_FINISH;
`else
            S_CLOSE:  w_state_nxt = S_FINISH;
`endif
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Session table: no reset needed, entries are only read below r_ok_cnt.
    always_ff @(posedge aclk) begin
        if (r_state == S_OPEN && w_rsp_hs && open_rsp_success)
            r_sid_tab[r_ok_cnt[SW-1:0]] <= open_rsp_sid;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_target    <= '0;
            r_words     <= '0;
            r_ip        <= '0;
            r_pkts      <= '0;
            r_req_cnt   <= '0;
            r_rsp_cnt   <= '0;
            r_ok_cnt    <= '0;
            r_fail_cnt  <= '0;
            r_retry_cnt <= '0;
            r_sp        <= '0;
            r_beat      <= '0;
            r_pkt_cnt   <= '0;
            r_done_sess <= '0;
            for (int i = 0; i < MAX_SESSIONS; i++) r_sent[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (runTx) begin
                    r_target    <= (numSessions > MAX16) ? MAX16 : numSessions;
                    r_words     <= pkgWordCount;
                    r_ip        <= serverIpAddress;
                    r_pkts      <= TotalPkgPerConn;
                    r_req_cnt   <= '0;
                    r_rsp_cnt   <= '0;
                    r_ok_cnt    <= '0;
                    r_fail_cnt  <= '0;
                    r_retry_cnt <= '0;
                    r_sp        <= '0;
                    r_beat      <= '0;
                    r_pkt_cnt   <= '0;
                    r_done_sess <= '0;
                    for (int i = 0; i < MAX_SESSIONS; i++) r_sent[i] <= '0;
                end
                S_OPEN: begin
                    // Request and response handshakes are independent and
                    // may both land in the same cycle.
                    if (w_req_hs) r_req_cnt <= r_req_cnt + 16'd1;
                    if (w_rsp_hs) begin
                        r_rsp_cnt <= r_rsp_cnt + 16'd1;
                        if (open_rsp_success) r_ok_cnt   <= r_ok_cnt + 16'd1;
                        else                  r_fail_cnt <= r_fail_cnt + 16'd1;
                    end
                    r_sp <= '0;
                end
                S_META: if (w_skip) r_sp <= w_sp_next;
                S_WAIT: if (w_stat_hs && tx_stat_error != 2'd0) begin
                    r_retry_cnt <= r_retry_cnt + 32'd1;
                    r_sp        <= w_sp_next;
                end
                S_DATA: if (w_data_hs) begin
                    if (w_last_beat) begin
                        r_beat                <= '0;
                        r_sent[r_sp[SW-1:0]]  <= r_sent[r_sp[SW-1:0]] + 8'd1;
                        r_pkt_cnt             <= r_pkt_cnt + 16'd1;
                        r_sp                  <= w_sp_next;
                        if (w_sess_full) r_done_sess <= r_done_sess + 16'd1;
                    end else begin
                        r_beat <= r_beat + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_tcp_client_gen.sv
// Directed bench for perf_tcp_client_gen: behavioural stack models answer
// open/meta/status, a data monitor checks every beat against the expected
// {session index, packet number, beat} pattern.
module tb_perf_tcp_client_gen;

    logic         aclk, aresetn, runTx;
    logic [15:0]  numSessions;
    logic [7:0]   pkgWordCount, TotalPkgPerConn;
    logic [31:0]  serverIpAddress;
    logic         open_req_valid, open_req_ready;
    logic [31:0]  open_req_ip;
    logic [15:0]  open_req_port;
    logic         open_rsp_valid, open_rsp_ready, open_rsp_success;
    logic [15:0]  open_rsp_sid;
    logic         tx_meta_valid, tx_meta_ready;
    logic [15:0]  tx_meta_sid, tx_meta_len;
    logic         tx_stat_valid, tx_stat_ready;
    logic [15:0]  tx_stat_sid;
    logic [1:0]   tx_stat_error;
    logic         tx_data_tvalid, tx_data_tready, tx_data_tlast;
    logic [511:0] tx_data_tdata;
    logic [63:0]  tx_data_tkeep;
    logic         busy, done;
    logic [15:0]  open_fail_cnt;
    logic [31:0]  retry_cnt;
`ifdef PERF_TCP_CLIENT_CLOSE_EN
    logic         close_req_valid, close_req_ready;
    logic [15:0]  close_req_sid;
`endif

    perf_tcp_client_gen dut (
        .aclk(aclk), .aresetn(aresetn), .runTx(runTx),
        .numSessions(numSessions), .pkgWordCount(pkgWordCount),
        .serverIpAddress(serverIpAddress), .TotalPkgPerConn(TotalPkgPerConn),
        .open_req_valid(open_req_valid), .open_req_ready(open_req_ready),
        .open_req_ip(open_req_ip), .open_req_port(open_req_port),
        .open_rsp_valid(open_rsp_valid), .open_rsp_ready(open_rsp_ready),
        .open_rsp_sid(open_rsp_sid), .open_rsp_success(open_rsp_success),
        .tx_meta_valid(tx_meta_valid), .tx_meta_ready(tx_meta_ready),
        .tx_meta_sid(tx_meta_sid), .tx_meta_len(tx_meta_len),
        .tx_stat_valid(tx_stat_valid), .tx_stat_ready(tx_stat_ready),
        .tx_stat_sid(tx_stat_sid), .tx_stat_error(tx_stat_error),
        .tx_data_tvalid(tx_data_tvalid), .tx_data_tready(tx_data_tready),
        .tx_data_tdata(tx_data_tdata), .tx_data_tkeep(tx_data_tkeep),
        .tx_data_tlast(tx_data_tlast),
`ifdef PERF_TCP_CLIENT_CLOSE_EN
        .close_req_valid(close_req_valid), .close_req_ready(close_req_ready),
        .close_req_sid(close_req_sid),
`endif
        .busy(busy), .done(done),
        .open_fail_cnt(open_fail_cnt), .retry_cnt(retry_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_vec = 0, n_err = 0;

    // stack model / scoreboard state
    int           n_open_req, n_meta, n_beats, n_tlast, n_done, n_stat;
    int           rsp_idx, rsp_pend, stat_pend;
    bit           rsp_taken, stat_taken, err_first, rand_rdy;
    logic [255:0] fail_mask;
    logic [15:0]  ok_q[$];
    logic [15:0]  meta_sid_q[$];
    logic [15:0]  last_meta_sid;
    int           sess_pkts[64];
    int           cur_sp, pkts_done, beat, exp_len;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wide(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // open responder: one response per accepted request, sid 0x0A00+index
    always @(negedge aclk) begin
        if (!aresetn) begin
            open_rsp_valid = 1'b0; rsp_pend = 0; rsp_taken = 1'b0;
        end else begin
            if (rsp_taken) open_rsp_valid = 1'b0;
            rsp_taken = 1'b0;
            if (!open_rsp_valid && rsp_pend > 0) begin
                open_rsp_valid   = 1'b1;
                open_rsp_sid     = 16'h0A00 + 16'(rsp_idx);
                open_rsp_success = !fail_mask[rsp_idx];
            end
        end
        #1;
        if (aresetn) begin
            if (open_req_valid && open_req_ready) begin
                n_open_req++; rsp_pend++;
                chk("open_ip", 64'(open_req_ip), 64'h0000_0000_C0A8_0001);
                chk("open_port", 64'(open_req_port), 64'd5001);
            end
            if (open_rsp_valid && open_rsp_ready) begin
                rsp_taken = 1'b1; rsp_pend--; rsp_idx++;
                if (open_rsp_success) ok_q.push_back(open_rsp_sid);
            end
        end
    end

    // meta monitor + status responder
    always @(negedge aclk) begin
        if (!aresetn) begin
            tx_stat_valid = 1'b0; stat_pend = 0; stat_taken = 1'b0;
        end else begin
            if (stat_taken) tx_stat_valid = 1'b0;
            stat_taken = 1'b0;
            if (!tx_stat_valid && stat_pend > 0) begin
                tx_stat_valid = 1'b1;
                tx_stat_sid   = last_meta_sid;
                tx_stat_error = (err_first && n_stat == 0) ? 2'd1 : 2'd0;
            end
        end
        #1;
        if (aresetn) begin
            if (tx_meta_valid && tx_meta_ready) begin
                bit found;
                found = 1'b0;
                n_meta++; stat_pend++;
                last_meta_sid = tx_meta_sid;
                meta_sid_q.push_back(tx_meta_sid);
                chk("meta_len", 64'(tx_meta_len), 64'(exp_len));
                foreach (ok_q[i]) if (ok_q[i] == tx_meta_sid) begin cur_sp = i; found = 1'b1; end
                chk("meta_sid_known", 64'(found), 64'd1);
            end
            if (tx_stat_valid && tx_stat_ready) begin
                stat_taken = 1'b1; stat_pend--; n_stat++;
            end
        end
    end

    // data monitor
    always @(negedge aclk) begin
        tx_data_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (!aresetn) begin
            beat = 0;
        end else begin
            if (done) n_done++;
            if (beat > 0) chk("tvalid_in_pkt", 64'(tx_data_tvalid), 64'd1);
            if (tx_data_tvalid && tx_data_tready) begin
                bit last;
                logic [63:0] w;
                last = (beat == int'(pkgWordCount) - 1);
                w = {16'(cur_sp), 16'(pkts_done), 32'(beat)};
                chk_wide("tdata", tx_data_tdata, {8{w}});
                chk("tkeep", tx_data_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
                chk("tlast", 64'(tx_data_tlast), 64'(last));
                n_beats++;
                if (last) begin
                    n_tlast++; pkts_done++; sess_pkts[cur_sp]++; beat = 0;
                end else begin
                    beat++;
                end
            end
        end
    end

    task automatic start_run(input logic [15:0] ns, input logic [7:0] w, input logic [7:0] p,
                             input logic [255:0] fm, input bit ef, input bit expect_open);
        numSessions = ns; pkgWordCount = w; TotalPkgPerConn = p;
        fail_mask = fm; err_first = ef; exp_len = int'(w) * 64;
        n_open_req = 0; n_meta = 0; n_beats = 0; n_tlast = 0; n_done = 0; n_stat = 0;
        rsp_idx = 0; pkts_done = 0; beat = 0; cur_sp = 0;
        ok_q.delete(); meta_sid_q.delete();
        foreach (sess_pkts[i]) sess_pkts[i] = 0;
        runTx = 1'b1;
        @(negedge aclk);
        runTx = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        if (expect_open) chk("start_open_valid", 64'(open_req_valid), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 5000) begin @(negedge aclk); k++; end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        #2;
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(negedge aclk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_open_req_valid"}, 64'(open_req_valid), 64'd0);
        chk({tag, "_open_rsp_ready"}, 64'(open_rsp_ready), 64'd0);
        chk({tag, "_meta_valid"},     64'(tx_meta_valid),  64'd0);
        chk({tag, "_stat_ready"},     64'(tx_stat_ready),  64'd0);
        chk({tag, "_tvalid"},         64'(tx_data_tvalid), 64'd0);
        chk({tag, "_busy"},           64'(busy),           64'd0);
        chk({tag, "_done"},           64'(done),           64'd0);
        chk({tag, "_fail_cnt"},       64'(open_fail_cnt),  64'd0);
        chk({tag, "_retry_cnt"},      64'(retry_cnt),      64'd0);
    endtask

    initial begin
        aresetn = 1'b0; runTx = 1'b0; rand_rdy = 1'b0;
        numSessions = '0; pkgWordCount = '0; TotalPkgPerConn = '0;
        serverIpAddress = 32'hC0A8_0001; fail_mask = '0; err_first = 1'b0;
        open_req_ready = 1'b1; tx_meta_ready = 1'b1;
        open_rsp_valid = 1'b0; open_rsp_sid = '0; open_rsp_success = 1'b0;
        tx_stat_valid = 1'b0; tx_stat_sid = '0; tx_stat_error = '0;
        tx_data_tready = 1'b1;
`ifdef PERF_TCP_CLIENT_CLOSE_EN
        close_req_ready = 1'b1;
`endif
        repeat (3) @(negedge aclk);
        chk_reset_outputs("rst");
        aresetn = 1'b1;
        @(negedge aclk);

        // 1: two sessions, 4 beats, 3 packets each
        start_run(16'd2, 8'd4, 8'd3, '0, 1'b0, 1'b1);
        wait_done("t1");
        chk("t1_opens", 64'(n_open_req), 64'd2);
        chk("t1_meta", 64'(n_meta), 64'd6);
        chk("t1_beats", 64'(n_beats), 64'd24);
        chk("t1_tlast", 64'(n_tlast), 64'd6);
        chk("t1_ndone", 64'(n_done), 64'd1);
        chk("t1_retry", 64'(retry_cnt), 64'd0);
        chk("t1_fail", 64'(open_fail_cnt), 64'd0);
        for (int i = 0; i < meta_sid_q.size(); i++)
            chk("t1_rr_sid", 64'(meta_sid_q[i]), (i % 2 == 0) ? 64'h0A00 : 64'h0A01);
        chk("t1_sess0", 64'(sess_pkts[0]), 64'd3);
        chk("t1_sess1", 64'(sess_pkts[1]), 64'd3);

        // 2: three sessions, second open fails
        start_run(16'd3, 8'd2, 8'd2, 256'b010, 1'b0, 1'b1);
        wait_done("t2");
        chk("t2_fail", 64'(open_fail_cnt), 64'd1);
        chk("t2_ok", 64'(ok_q.size()), 64'd2);
        chk("t2_meta", 64'(n_meta), 64'd4);
        chk("t2_beats", 64'(n_beats), 64'd8);
        chk("t2_sess0", 64'(sess_pkts[0]), 64'd2);
        chk("t2_sess1", 64'(sess_pkts[1]), 64'd2);

        // 3: first status returns an error
        start_run(16'd2, 8'd1, 8'd2, '0, 1'b1, 1'b1);
        wait_done("t3");
        chk("t3_retry", 64'(retry_cnt), 64'd1);
        chk("t3_meta", 64'(n_meta), 64'd5);
        chk("t3_pkts", 64'(n_tlast), 64'd4);
        chk("t3_sess0", 64'(sess_pkts[0]), 64'd2);
        chk("t3_sess1", 64'(sess_pkts[1]), 64'd2);

        // 4: request more sessions than the table holds
        start_run(16'd200, 8'd1, 8'd1, '0, 1'b0, 1'b1);
        wait_done("t4");
        chk("t4_opens", 64'(n_open_req), 64'd64);
        chk("t4_pkts", 64'(n_tlast), 64'd64);
        chk("t4_sess63", 64'(sess_pkts[63]), 64'd1);

        // 5: random tready, second runTx mid-run
        rand_rdy = 1'b1;
        start_run(16'd2, 8'd5, 8'd2, '0, 1'b0, 1'b1);
        repeat (15) @(negedge aclk);
        runTx = 1'b1;
        @(negedge aclk);
        runTx = 1'b0;
        wait_done("t5");
        rand_rdy = 1'b0;
        chk("t5_opens", 64'(n_open_req), 64'd2);
        chk("t5_beats", 64'(n_beats), 64'd20);
        repeat (5) @(negedge aclk);
        chk("t5_idle_busy", 64'(busy), 64'd0);
        chk("t5_ndone", 64'(n_done), 64'd1);

        // 6: reset during SEND_DATA, then a zero-length run
        start_run(16'd2, 8'd8, 8'd4, '0, 1'b0, 1'b1);
        begin
            int k;
            k = 0;
            while (n_beats < 3 && k < 1000) begin @(negedge aclk); k++; end
            chk("t6_reached_data", 64'(n_beats >= 3), 64'd1);
        end
        aresetn = 1'b0;
        @(negedge aclk);
        chk_reset_outputs("t6_rst");
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        start_run(16'd2, 8'd0, 8'd3, '0, 1'b0, 1'b1);
        wait_done("t6");
        chk("t6_opens", 64'(n_open_req), 64'd2);
        chk("t6_meta", 64'(n_meta), 64'd0);
        chk("t6_beats", 64'(n_beats), 64'd0);
        chk("t6_ndone", 64'(n_done), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/perf_tcp_client_gen.md
# perf_tcp_client_gen

Traffic-generating stage of the TCP client performance example. It sits directly downstream of the AXI-Lite control parser and consumes its `runTx`, `numSessions`, `pkgWordCount`, `serverIpAddress` and `TotalPkgPerConn` outputs. For each run it opens the requested number of TCP sessions to the server, then sends `TotalPkgPerConn` packets of `pkgWordCount` 64-byte beats per session, round-robin across sessions. All traffic goes through the network stack's open, meta, status and data interfaces.

## Interface
Parameters:
- `MAX_SESSIONS`, default 64: session-ID table depth; power of two.
- `SERVER_PORT`, default 16'd5001: destination port on every open request.
- `DATA_BITS`, default 512: tx data width; one beat is 64 bytes.

Ports:
- `aclk`  in  1  clock
- `aresetn`  in  1  reset; synchronous, active-low
- `runTx`  in  1  single-cycle start pulse
- `numSessions`  in  16  sessions to open
- `pkgWordCount`  in  8  beats per packet
- `serverIpAddress`  in  32  destination IP
- `TotalPkgPerConn`  in  8  packets per session
- `open_req_valid`/`open_req_ready`  out/in  1  open request handshake
- `open_req_ip`  out  32  destination IP for the open request
- `open_req_port`  out  16  destination port for the open request
- `open_rsp_valid`/`open_rsp_ready`  in/out  1  open response handshake
- `open_rsp_sid`  in  16  session ID returned by the stack
- `open_rsp_success`  in  1  1 = session opened
- `tx_meta_valid`/`tx_meta_ready`  out/in  1  tx meta handshake
- `tx_meta_sid`  out  16  session ID for the packet
- `tx_meta_len`  out  16  packet length in bytes
- `tx_stat_valid`/`tx_stat_ready`  in/out  1  tx status handshake
- `tx_stat_sid`  in  16  session ID of the status
- `tx_stat_error`  in  2  0 = ok, nonzero = retry
- `tx_data_tvalid`/`tx_data_tready`  out/in  1  tx data handshake
- `tx_data_tdata`  out  DATA_BITS  payload
- `tx_data_tkeep`  out  DATA_BITS/8  byte enables
- `tx_data_tlast`  out  1  last beat of packet
- `close_req_valid`/`close_req_ready`  out/in  1  close request handshake (macro only)
- `close_req_sid`  out  16  session to close (macro only)
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at end of run
- `open_fail_cnt`  out  16  failed opens in the last run
- `retry_cnt`  out  32  tx_stat retries in the last run

## Operation
- Run parameters are latched when `runTx` is sampled in IDLE. `runTx` in any other state is ignored.
- Target session count is `min(numSessions, MAX_SESSIONS)`.
- Packet length: `tx_meta_len = pkgWordCount * 64`, zero-extended into 16 bits (max 16320).
- FSM states: IDLE → OPEN → SEND_META → WAIT_STAT → SEND_DATA → (CLOSE) → FINISH → IDLE.
- OPEN:
  - Issues target open requests back-to-back; `req_cnt` advances on each handshake.
  - `open_rsp_ready` is held at 1 throughout OPEN.
  - Each successful response writes `open_rsp_sid` into table[`ok_cnt`] and increments `ok_cnt`. A failed response increments `open_fail_cnt`.
  - OPEN exits when `rsp_cnt == target`.
- Leaving OPEN:
  - If `ok_cnt == 0`, `pkgWordCount == 0` or `TotalPkgPerConn == 0`, go to CLOSE, or to FINISH when the macro is absent.
  - Otherwise go to SEND_META with session pointer `sp = 0`.
- SEND_META: presents table[sp] and the packet length. Only one packet is outstanding at a time.
- WAIT_STAT: `tx_stat_ready = 1`.
  - `tx_stat_error == 0`: go to SEND_DATA.
  - Nonzero: increment `retry_cnt`, advance `sp` and return to SEND_META. The packet is not counted.
- SEND_DATA:
  - Emits `pkgWordCount` beats. `tkeep` is all ones.
  - `tlast` is set on beat `pkgWordCount-1`.
  - `tdata` is the 64-bit word {sp[15:0], pkt_cnt[15:0], beat[31:0]} replicated across the bus.
- After the last beat of a packet:
  - Increment `pkt_sent[sp]`.
  - Advance `sp`, wrapping at `ok_cnt` and skipping sessions whose count has reached `TotalPkgPerConn`.
  - When all `ok_cnt` sessions have completed, go to CLOSE/FINISH.
- FINISH: pulse `done`, return to IDLE.
- Counters `open_fail_cnt` and `retry_cnt` clear at run start and hold their values after the run.

## Timing
- Reset values: every valid output 0, `open_rsp_ready` 0, `tx_stat_ready` 0, `busy` 0, `done` 0, all counters 0, FSM in IDLE.
- `runTx` sampled at edge N gives `busy = 1` and `open_req_valid = 1` from cycle N+1.
- Every valid stays asserted, with payload stable, until its ready is seen. No combinational ready→valid paths.
- SEND_DATA sustains one beat per cycle while `tready = 1`. `tvalid` never drops mid-packet.
- If an open response arrives in the same cycle as a request handshake, both are counted.
- `done` is asserted the cycle after the final beat (or final close) handshake; `busy` falls in the same cycle.
- Reset mid-run aborts immediately with no closes issued; the next run starts clean.

## Configuration
- `PERF_TCP_CLIENT_CLOSE_EN` defined:
  - CLOSE state issues one `close_req` per table entry 0..`ok_cnt-1`, in order, each waiting for `close_req_ready`.
  - FINISH follows the last close.
- Undefined: the close ports are absent, CLOSE is never entered, and sessions are left open.

## Test plan
- numSessions=2, pkgWordCount=4, TotalPkgPerConn=3, all ready, all opens ok, no errors → 6 meta beats with len=256, alternating sid A/B, 24 data beats, `tlast` every 4th beat, `done` once, `retry_cnt=0`.
- numSessions=3 with second open failing → `open_fail_cnt=1`, traffic only on 2 sids.
- First tx_stat returns error=1 → `retry_cnt=1`, that packet reissued later, total packets still `ok_cnt*TotalPkgPerConn`.
- numSessions=200 with MAX_SESSIONS=64 → exactly 64 open requests.
- `tready` toggling 50% random, plus `runTx` pulsed mid-run → payload pattern intact, second pulse ignored.
- Reset asserted during SEND_DATA → all outputs at reset values the next cycle; a fresh run with pkgWordCount=0 → opens only, `done` with no data beats.
